gate_result_checker: RTL and testbench
======================================

Name: gate_result_checker

Overview:
- Receive side of the 9-bit gate-result vector produced by the team's gate-level primitive block: result[0]=~a, [1]=a&b, [2]=~(a&b), [3]=a|b, [4]=~(a|b), [5]=a^b, [6]=~(a^b), [7]=~(a^b^c), [8]=a&b&c.
- Accepts result vectors over a valid/ready stream and recovers the three inputs (a, b, c).
- Re-encodes the recovered inputs and flags every inconsistent bit.
- Keeps vector and error statistics plus a capture of the first failing vector; used as an on-chip self-check for the gate block.

Parameters:
- CNT_W, 16, width of vec_count and err_count (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of counters and first-error capture.
- in_valid  input  1  in_result is valid.
- in_ready  output  1  checker can accept.
- in_result  input  9  gate-result vector.
- out_valid  output  1  decoded result is valid.
- out_ready  input  1  downstream accepts.
- out_inputs  output  3  recovered {c,b,a}.
- out_error  output  1  vector inconsistent.
- out_mismatch  output  9  in_result XOR re-encoded vector.
- vec_count  output  CNT_W  vectors accepted.
- err_count  output  CNT_W  vectors with out_error=1.
- first_err_valid  output  1  a failing vector has been captured.
- first_err_vec  output  9  first failing in_result.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_inputs=0, out_error=0, out_mismatch=0, vec_count=0, err_count=0, first_err_valid=0, first_err_vec=0. in_ready=1 on the first cycle after release.
- Handshake:
  - Accept when in_valid & in_ready.
  - in_ready = ~out_valid | out_ready, so a full-rate stream is sustained.
  - Output register loads on accept. Latency is 1 cycle: data accepted at edge N is visible after edge N.
  - out_valid clears on out_ready with no new accept.
  - Output fields hold stable while out_valid & ~out_ready.
- Decode (combinational, on in_result):
  - a = ~r[0]
  - b = r[5]^a
  - c = ~r[7]^a^b
- Re-encode {c,b,a} with the table in Overview to get exp[8:0].
- out_mismatch = in_result ^ exp; out_error = |out_mismatch.
- Corruption in bits 0, 5 or 7 is decoded through and reported as mismatches in the other bits.
- Counters, on accept only:
  - vec_count += 1.
  - err_count += 1 if error.
  - Both saturate at 2^CNT_W-1 with no wrap.
- First-error capture: on the first accepted erroneous vector while first_err_valid=0, latch in_result and set first_err_valid. It stays sticky until clear or reset.
- clear: zeroes the counters and the first-error capture at the next edge.
  - clear has priority over a same-cycle accept: that vector is not counted and not captured.
  - The output register still loads, so clear does not affect the data stream.
- Reset mid-transfer: the in-flight output is discarded and out_valid drops immediately (asynchronously).
- No state machine beyond the output valid bit. The sequential behaviour is the pipeline register, the counters and the sticky capture.

Decomposition:
- Shared package gate_result_pkg:
  - RES_W=9.
  - Bit-index constants RES_NOT=0, RES_AND=1, RES_NAND=2, RES_OR=3, RES_NOR=4, RES_XOR=5, RES_XNOR=6, RES_XNOR3=7, RES_AND3=8.
  - Encode function f(a,b,c) -> 9 bits, shared with the bench.
- One sub-module, gate_result_decode: combinational in_result -> {c,b,a}, exp, mismatch, error. The top holds the handshake register, counters and capture.

Test Plan:
- Reset, then send 0x0AC (a=1,b=0,c=1) with out_ready=1 -> next cycle out_valid=1, out_inputs=3'b101, out_error=0, out_mismatch=0, vec_count=1.
- Stream all 8 clean vectors back-to-back, including 0x0D5 (000) and 0x14A (111) -> one per cycle, in_ready stays 1, correct {c,b,a} each, err_count=0, vec_count=8.
- Send 0x0AE (bit1 flipped from 0x0AC) -> out_error=1, out_mismatch=0x002, err_count=1, first_err_valid=1, first_err_vec=0x0AE. Then send 0x0AF -> first_err_vec stays 0x0AE, err_count=2.
- Backpressure: hold out_ready=0 with in_valid=1 -> in_ready=0 after the first accept, outputs stable, vec_count=1. Release out_ready -> the second vector is accepted the same cycle.
- clear asserted together with accepting 0x0AE -> counters 0, first_err_valid=0, yet out_error=1 is presented. Assert rst_n=0 mid-stream -> out_valid=0 immediately.
- Saturation with CNT_W=2: accept 5 erroneous vectors -> vec_count=3, err_count=3, with no wrap.

Source files
------------

// File: rtl/gate_result_pkg.sv
// Shared definitions for the gate-result vector: bit layout, response struct
// and the reference encoder used by both the checker and its bench.
package gate_result_pkg;

  localparam int RES_W     = 9;
  localparam int RES_NOT   = 0;
  localparam int RES_AND   = 1;
  localparam int RES_NAND  = 2;
  localparam int RES_OR    = 3;
  localparam int RES_NOR   = 4;
  localparam int RES_XOR   = 5;
  localparam int RES_XNOR  = 6;
  localparam int RES_XNOR3 = 7;
  localparam int RES_AND3  = 8;

  typedef struct packed {
    logic [2:0]       inputs;    // {c,b,a}
    logic             error;
    logic [RES_W-1:0] mismatch;
  } dec_rsp_t;

  function automatic logic [RES_W-1:0] encode(input logic a, input logic b, input logic c);
    logic [RES_W-1:0] r;
    r            = '0;
    r[RES_NOT]   = ~a;
    r[RES_AND]   = a & b;
    r[RES_NAND]  = ~(a & b);
    r[RES_OR]    = a | b;
    r[RES_NOR]   = ~(a | b);
    r[RES_XOR]   = a ^ b;
    r[RES_XNOR]  = ~(a ^ b);
    r[RES_XNOR3] = ~(a ^ b ^ c);
    r[RES_AND3]  = a & b & c;
    return r;
  endfunction

endpackage

// File: rtl/gate_result_decode.sv
// Combinational recovery of {c,b,a} from a result vector and per-bit
// consistency check against the re-encoded vector.
module gate_result_decode
  import gate_result_pkg::*;
(
  input  logic [RES_W-1:0] in_result,
  output dec_rsp_t         rsp
);

  logic             a, b, c;
  logic [RES_W-1:0] exp_vec;

  // Only NOT, XOR and XNOR3 are needed to solve for the inputs; the rest
  // are pure redundancy for checking.
  always_comb begin
    a       = ~in_result[RES_NOT];
    b       = in_result[RES_XOR] ^ a;
    c       = ~in_result[RES_XNOR3] ^ a ^ b;
    exp_vec = encode(a, b, c);
    rsp.inputs   = {c, b, a};
    rsp.mismatch = in_result ^ exp_vec;
    rsp.error    = |rsp.mismatch;
  end

endmodule

// File: rtl/gate_result_checker.sv
// Stream checker for gate-result vectors: one-deep output register with
// full-rate handshake, saturating statistics and sticky first-error capture.
module gate_result_checker
  import gate_result_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_inputs,
  output logic             out_error,
  output logic [RES_W-1:0] out_mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [RES_W-1:0] first_err_vec
);

  dec_rsp_t         dec;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  dec_rsp_t         out_q, out_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             fe_valid_q, fe_valid_d;
  logic [RES_W-1:0] fe_vec_q, fe_vec_d;

  gate_result_decode u_decode (
    .in_result (in_result),
    .rsp       (dec)
  );

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    fe_valid_d  = fe_valid_q;
    fe_vec_d    = fe_vec_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_d       = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // clear wins over statistics only; the data path above is unaffected
    if (clear) begin
      vec_count_d = '0;
      err_count_d = '0;
      fe_valid_d  = 1'b0;
      fe_vec_d    = '0;
    end else if (accept) begin
      if (vec_count_q != '1) vec_count_d = vec_count_q + CNT_W'(1);
      if (dec.error && err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      if (dec.error && !fe_valid_q) begin
        fe_valid_d = 1'b1;
        fe_vec_d   = in_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      fe_valid_q  <= 1'b0;
      fe_vec_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      fe_valid_q  <= fe_valid_d;
      fe_vec_q    <= fe_vec_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_inputs      = out_q.inputs;
  assign out_error       = out_q.error;
  assign out_mismatch    = out_q.mismatch;
  assign vec_count       = vec_count_q;
  assign err_count       = err_count_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_vec   = fe_vec_q;

endmodule

// File: tb/tb_gate_result_checker.sv
// Bench for gate_result_checker: directed scenarios plus a randomized stream
// scored against a transaction-level model.
module tb_gate_result_checker;
  import gate_result_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n, clear, in_valid, out_ready;
  logic [RES_W-1:0] in_result;
  logic             in_ready, out_valid, out_error, fev;
  logic [2:0]       out_inputs;
  logic [RES_W-1:0] out_mismatch, fe_vec;
  logic [15:0]      vec_count, err_count;
  logic             s_in_ready, s_out_valid, s_out_error, s_fev;
  logic [2:0]       s_out_inputs;
  logic [RES_W-1:0] s_out_mismatch, s_fe_vec;
  logic [1:0]       s_vec_count, s_err_count;

  int checks = 0;
  int failures = 0;

  // corrupting only these bits leaves the recovered inputs intact
  localparam logic [RES_W-1:0] SAFE_MASK = 9'b1_0101_1110;

  always #5 clk = ~clk;

  gate_result_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_inputs(out_inputs), .out_error(out_error), .out_mismatch(out_mismatch),
    .vec_count(vec_count), .err_count(err_count),
    .first_err_valid(fev), .first_err_vec(fe_vec)
  );

  gate_result_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_result(in_result), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_inputs(s_out_inputs), .out_error(s_out_error), .out_mismatch(s_out_mismatch),
    .vec_count(s_vec_count), .err_count(s_err_count),
    .first_err_valid(s_fev), .first_err_vec(s_fe_vec)
  );

  task automatic drive(input logic v, input logic [RES_W-1:0] r, input logic rdy, input logic clr);
    @(negedge clk);
    in_valid = v; in_result = r; out_ready = rdy; clear = clr;
  endtask

  task automatic idle_clear();
    drive(1'b0, '0, 1'b1, 1'b1);
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_result = '0;
    #12;
    checks++;
    if ({out_valid, out_inputs, out_error, out_mismatch, vec_count, err_count, fev, fe_vec} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b in=%b err=%b mm=%h vc=%0d ec=%0d fev=%b fe=%h want all zero",
               out_valid, out_inputs, out_error, out_mismatch, vec_count, err_count, fev, fe_vec);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    drive(1'b1, 9'h0AC, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_inputs !== 3'b101 || out_error !== 1'b0 ||
        out_mismatch !== 9'h000 || vec_count !== 16'd1) begin
      failures++;
      $display("FAIL single_0AC got v=%b in=%b err=%b mm=%h vc=%0d want 1 101 0 000 1",
               out_valid, out_inputs, out_error, out_mismatch, vec_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] abc;
    idle_clear();
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      drive(1'b1, encode(abc[0], abc[1], abc[2]), 1'b1, 1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_inputs !== abc || out_error !== 1'b0) begin
        failures++;
        $display("FAIL b2b_decode[%0d] got v=%b in=%b err=%b want 1 %b 0", i, out_valid, out_inputs, out_error, abc);
      end
    end
    checks++;
    if (vec_count !== 16'd8 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL b2b_counts got vc=%0d ec=%0d want 8 0", vec_count, err_count);
    end
  endtask

  task automatic test_error_capture();
    idle_clear();
    drive(1'b1, 9'h0AE, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_error !== 1'b1 || out_mismatch !== 9'h002 || out_inputs !== 3'b101 || err_count !== 16'd1 ||
        fev !== 1'b1 || fe_vec !== 9'h0AE) begin
      failures++;
      $display("FAIL err_first got err=%b mm=%h in=%b ec=%0d fev=%b fe=%h want 1 002 101 1 1 0ae",
               out_error, out_mismatch, out_inputs, err_count, fev, fe_vec);
    end
    // bit0 flipped: decoded as a=0,b=1,c=1 -> expected 0x0AD, so only bit1 disagrees
    drive(1'b1, 9'h0AF, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_error !== 1'b1 || out_inputs !== 3'b110 || out_mismatch !== 9'h002 ||
        err_count !== 16'd2 || fe_vec !== 9'h0AE || fev !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got err=%b in=%b mm=%h ec=%0d fev=%b fe=%h want 1 110 002 2 1 0ae",
               out_error, out_inputs, out_mismatch, err_count, fev, fe_vec);
    end
  endtask

  task automatic test_backpressure();
    idle_clear();
    drive(1'b1, 9'h0D5, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_result = 9'h14A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inputs !== 3'b000 || vec_count !== 16'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b in=%b vc=%0d want 0 1 000 1",
                 i, in_ready, out_valid, out_inputs, vec_count);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_inputs !== 3'b111 || vec_count !== 16'd2) begin
      failures++;
      $display("FAIL bp_release got v=%b in=%b vc=%0d want 1 111 2", out_valid, out_inputs, vec_count);
    end
  endtask

  task automatic test_clear_and_reset();
    drive(1'b1, 9'h0AE, 1'b1, 1'b1);
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (vec_count !== 16'd0 || err_count !== 16'd0 || fev !== 1'b0 || out_valid !== 1'b1 || out_error !== 1'b1) begin
      failures++;
      $display("FAIL clear_accept got vc=%0d ec=%0d fev=%b v=%b err=%b want 0 0 0 1 1",
               vec_count, err_count, fev, out_valid, out_error);
    end
    drive(1'b1, 9'h0D5, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || vec_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_midstream got v=%b vc=%0d want 0 0", out_valid, vec_count);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    idle_clear();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'h0AE, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    checks++;
    if (s_vec_count !== 2'd3 || s_err_count !== 2'd3 || vec_count !== 16'd5 || err_count !== 16'd5) begin
      failures++;
      $display("FAIL saturation got sat vc=%0d ec=%0d wide vc=%0d ec=%0d want 3 3 5 5",
               s_vec_count, s_err_count, vec_count, err_count);
    end
  endtask

  task automatic test_random();
    logic             m_valid, m_err, m_fev, v, rdy, m_ready;
    logic [2:0]       m_in, abc;
    logic [RES_W-1:0] m_mm, m_fe, flip, r;
    int               m_vc, m_ec, bad;
    idle_clear();
    m_valid = 1'b0; m_in = '0; m_err = 1'b0; m_mm = '0; m_fev = 1'b0; m_fe = '0;
    m_vc = 0; m_ec = 0; bad = 0;
    // DUT output register still holds the last saturation vector, but is invalid
    for (int i = 0; i < 300; i++) begin
      abc  = 3'($urandom_range(0, 7));
      flip = ($urandom_range(0, 3) == 0) ? (9'($urandom) & SAFE_MASK) : 9'h000;
      r    = encode(abc[0], abc[1], abc[2]) ^ flip;
      v    = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      drive(v, r, rdy, 1'b0);
      #1;
      m_ready = ~m_valid | rdy;
      if (in_ready !== m_ready) begin
        bad++;
        if (bad < 5) $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, m_ready);
      end
      @(posedge clk);
      if (v && m_ready) begin
        m_valid = 1'b1; m_in = abc; m_mm = flip; m_err = (flip != 0);
        m_vc++;
        if (m_err) m_ec++;
        if (m_err && !m_fev) begin m_fev = 1'b1; m_fe = r; end
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      #1;
      if (out_valid !== m_valid || (m_valid && (out_inputs !== m_in || out_mismatch !== m_mm || out_error !== m_err)) ||
          vec_count !== 16'(m_vc) || err_count !== 16'(m_ec) || fev !== m_fev || fe_vec !== m_fe) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_out[%0d] got v=%b in=%b mm=%h vc=%0d ec=%0d fe=%h want %b %b %h %0d %0d %h",
                   i, out_valid, out_inputs, out_mismatch, vec_count, err_count, fe_vec,
                   m_valid, m_in, m_mm, m_vc, m_ec, m_fe);
      end
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rand_stream got %0d bad cycles want 0", bad); end
    checks++;
    if (m_vc == 0 || vec_count !== 16'(m_vc)) begin
      failures++;
      $display("FAIL rand_total got vc=%0d want %0d (nonzero)", vec_count, m_vc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_error_capture();
    test_backpressure();
    test_clear_and_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
